pump_interlock_driver: RTL
==========================

// Module: pump_interlock_driver
// PURPOSE
// - Sits directly downstream of the aquarium controller: takes its hot/cold pump requests, drives the physical pump enables.
// - Guarantees hot and cold pumps are never on together and enforces dead time between them.
// - Enforces a minimum on-time, so requests cannot short-cycle a pump.
// - Cuts a pump that runs longer than a maximum on-time and latches a fault until it is cleared.
// PARAMETERS
// CNT_W          31             width of the internal cycle counter
// DEAD_CYCLES    100_000_000    off cycles forced after any pump stops (2 s @ 50 MHz); >=1
// MIN_ON_CYCLES  250_000_000    minimum cycles a pump stays on once started (5 s); >=1
// MAX_ON_CYCLES  1_500_000_000  on cycles after which a still-requested pump faults (30 s); >MIN_ON_CYCLES
// PORTS
// clk            in   1  system clock, all logic on rising edge
// clr            in   1  synchronous reset, active-high
// req_hot        in   1  hot pump request (pump_control_hot from the controller)
// req_cold       in   1  cold pump request (pump_control_cold from the controller)
// fault_clr      in   1  one-cycle pulse; acknowledges a latched fault
// pump_hot_en    out  1  hot pump drive, registered
// pump_cold_en   out  1  cold pump drive, registered
// fault          out  1  over-run fault, registered, sticky
// req_conflict   out  1  one-cycle pulse: both requests seen in IDLE
// state          out  3  current FSM state: IDLE=0 HOT_ON=1 COLD_ON=2 DEAD=3 FAULT=4
// BEHAVIOUR
// - Reset: clr=1 at an edge -> state=IDLE, cnt=0, every output 0. Reset applies in any state, including mid-run.
// - Outputs are registered together with the state. pump_hot_en=1 iff state=HOT_ON; pump_cold_en=1 iff state=COLD_ON.
// - Request-to-enable latency: 1 clock.
// - cnt is zeroed on every state entry and increments by 1 each cycle the state is held. It never wraps, because the
//   maximum value reached is MAX_ON_CYCLES-1.
// - IDLE:
//   - req_hot&!req_cold -> HOT_ON.
//   - req_cold&!req_hot -> COLD_ON.
//   - Both requests high -> stay in IDLE and pulse req_conflict for 1 cycle.
//   - Neither request high -> stay in IDLE.
// - HOT_ON (COLD_ON symmetric):
//   - Release condition = !req_hot | req_cold.
//   - At cnt>=MIN_ON_CYCLES-1 with release true -> DEAD.
//   - Otherwise at cnt==MAX_ON_CYCLES-1 with req_hot still high -> FAULT.
//   - If release and max are reached on the same cycle, release wins (go to DEAD).
// - On-time bounds: enable is high for at least MIN_ON_CYCLES and at most MAX_ON_CYCLES consecutive cycles.
// - DEAD:
//   - Both enables 0 and all requests ignored.
//   - At cnt==DEAD_CYCLES-1 -> IDLE, so the off gap is exactly DEAD_CYCLES cycles.
//   - A held or swapped request restarts the pump from IDLE, so the off-to-on gap is DEAD_CYCLES+1 cycles.
// - FAULT:
//   - Both enables 0, fault=1.
//   - fault_clr=1 -> DEAD, and fault drops at that same edge.
//   - fault_clr is ignored in every other state.
// - Invariants:
//   - pump_hot_en & pump_cold_en never both 1.
//   - The two enables never switch directly from one to the other.
// - Unused state encodings 5-7 -> IDLE on the next edge, with outputs 0.
// TESTING (bench overrides: DEAD_CYCLES=4, MIN_ON_CYCLES=3, MAX_ON_CYCLES=10)
// T1 Reset: clr=1 for 2 cycles in any state -> state=0, pump_hot_en=pump_cold_en=fault=req_conflict=0.
// T2 Hot run: req_hot=1 for 6 cycles, then 0 -> pump_hot_en rises 1 cycle after req_hot, is high 6 cycles,
//    then is low 4 cycles in DEAD (state=3), then state=0.
// T3 Min-on: req_hot=1 for 1 cycle only -> pump_hot_en high exactly 3 cycles, then DEAD for 4 cycles.
// T4 Swap: req_hot held 5 cycles, then req_cold=1/req_hot=0 held -> hot off, 4 cycles with both off,
//    state IDLE for 1 cycle, then pump_cold_en=1; the assertion "never both high" holds throughout.
// T5 Over-run: req_cold held 20 cycles -> pump_cold_en high exactly 10 cycles, then fault=1, state=4, both off.
//    fault_clr pulse -> fault=0, 4 cycles DEAD, then IDLE.
// T6 Conflict/reset: req_hot=req_cold=1 in IDLE -> state stays 0, req_conflict pulses once.
//    clr=1 on cycle 2 of HOT_ON -> pump_hot_en=0 on the next cycle, state=0.

Source files
------------

// File: rtl/pump_interlock_if.sv
// Pump interlock signal bundle: controller-side requests in, pump drives and status out.
// The master modport is the aquarium controller; the slave modport is the interlock driver.
interface pump_interlock_if;
    logic       req_hot;
    logic       req_cold;
    logic       fault_clr;
    logic       pump_hot_en;
    logic       pump_cold_en;
    logic       fault;
    logic       req_conflict;
    logic [2:0] state;

    modport master (
        output req_hot,
        output req_cold,
        output fault_clr,
        input  pump_hot_en,
        input  pump_cold_en,
        input  fault,
        input  req_conflict,
        input  state
    );

    modport slave (
        input  req_hot,
        input  req_cold,
        input  fault_clr,
        output pump_hot_en,
        output pump_cold_en,
        output fault,
        output req_conflict,
        output state
    );
endinterface

// File: rtl/pump_interlock_driver.sv
// Hot/cold pump interlock: mutual exclusion, dead time, minimum and maximum on-time,
// and a sticky over-run fault that needs an explicit acknowledge.
module pump_interlock_driver #(
    parameter int CNT_W         = 31,
    parameter int DEAD_CYCLES   = 100_000_000,
    parameter int MIN_ON_CYCLES = 250_000_000,
    parameter int MAX_ON_CYCLES = 1_500_000_000
) (
    input  logic              clk,
    input  logic              clr,
    pump_interlock_if.slave   pif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOT_ON  = 3'd1,
        COLD_ON = 3'd2,
        DEAD    = 3'd3,
        FAULT   = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_ON_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hot_en_q, hot_en_d;
    logic             cold_en_q, cold_en_d;
    logic             fault_q, fault_d;
    logic             conflict_q, conflict_d;

    logic             hot_release;
    logic             cold_release;

    // A pump is released when its request drops or the opposite pump is asked for.
    assign hot_release  = !pif.req_hot  || pif.req_cold;
    assign cold_release = !pif.req_cold || pif.req_hot;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        conflict_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (pif.req_hot && !pif.req_cold) begin
                    state_d = HOT_ON;
                end else if (pif.req_cold && !pif.req_hot) begin
                    state_d = COLD_ON;
                end else if (pif.req_hot && pif.req_cold) begin
                    conflict_d = 1'b1;
                end
            end
            HOT_ON: begin
                if (cnt_q >= MIN_LAST && hot_release) begin
                    state_d = DEAD;
                end else if (cnt_q == MAX_LAST && pif.req_hot) begin
                    state_d = FAULT;
                end
            end
            COLD_ON: begin
                if (cnt_q >= MIN_LAST && cold_release) begin
                    state_d = DEAD;
                end else if (cnt_q == MAX_LAST && pif.req_cold) begin
                    state_d = FAULT;
                end
            end
            DEAD: begin
                if (cnt_q == DEAD_LAST) begin
                    state_d = IDLE;
                end
            end
            FAULT: begin
                if (pif.fault_clr) begin
                    state_d = DEAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Counter restarts on every state entry; saturating keeps long IDLE/FAULT stays from wrapping.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != MAX_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        hot_en_d  = (state_d == HOT_ON);
        cold_en_d = (state_d == COLD_ON);
        fault_d   = (state_d == FAULT);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hot_en_q   <= 1'b0;
            cold_en_q  <= 1'b0;
            fault_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hot_en_q   <= hot_en_d;
            cold_en_q  <= cold_en_d;
            fault_q    <= fault_d;
            conflict_q <= conflict_d;
        end
    end

    assign pif.pump_hot_en  = hot_en_q;
    assign pif.pump_cold_en = cold_en_q;
    assign pif.fault        = fault_q;
    assign pif.req_conflict = conflict_q;
    assign pif.state        = state_q;

endmodule
